// File: rtl/t09_sound_pkg.sv
// Shared types and constants for the tone generator.
// Tone codes are half-periods in prescaler ticks.
package t09_sound_pkg;

    typedef enum logic {
        StIdle,
        StPlay
    } state_e;

    localparam int unsigned DefPrescale = 100;
    localparam int unsigned DefDurTicks = 10000;

    localparam logic [7:0] ToneGood = 8'd89;
    localparam logic [7:0] ToneBad  = 8'd126;
    localparam logic [7:0] ToneMove = 8'd149;

endpackage

// File: rtl/t09_tick_prescaler.sv
// Divides the system clock down to the tone tick.
// Emits one tick per PRESCALE enabled cycles; clr restarts the count.
module t09_tick_prescaler
    import t09_sound_pkg::*;
#(
    parameter int unsigned PRESCALE = DefPrescale
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned PreW = $clog2(PRESCALE);
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        tick_o    = 1'b0;
        if (clr_i) begin
            pre_cnt_d = '0;
        end else if (en_i) begin
            if (pre_cnt_q == PreLast) begin
                pre_cnt_d = '0;
                tick_o    = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/t09_sound_generator.sv
// Plays a fixed-length square-wave tone for each new non-zero tone code.
// A held code triggers once; a different code restarts the tone.
module t09_sound_generator
    import t09_sound_pkg::*;
#(
    parameter int unsigned PRESCALE  = DefPrescale,
    parameter int unsigned DUR_TICKS = DefDurTicks
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] freq_i,
    input  logic       mute_i,
    output logic       square_o,
    output logic       busy_o
);

    localparam int unsigned DurW = (DUR_TICKS > 1) ? $clog2(DUR_TICKS) : 1;
    localparam logic [DurW-1:0] DurLast = DurW'(DUR_TICKS - 1);

    state_e          state_q, state_d;
    logic [7:0]      prev_q;
    logic [7:0]      freq_q, freq_d;
    logic [7:0]      half_cnt_q, half_cnt_d;
    logic [DurW-1:0] dur_cnt_q, dur_cnt_d;
    logic            tone_q, tone_d;
    logic            trigger;
    logic            playing;
    logic            tick;

    assign trigger = (freq_i != 8'd0) && (freq_i != prev_q);
    assign playing = (state_q == StPlay);

    t09_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .nrst   (nrst),
        .clr_i  (trigger),
        .en_i   (playing),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        tone_d     = tone_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d    = StPlay;
                    freq_d     = freq_i;
                    half_cnt_d = 8'd0;
                    dur_cnt_d  = '0;
                    tone_d     = 1'b0;
                end
            end
            StPlay: begin
                // A trigger on the expiry cycle wins: the tone restarts.
                if (trigger) begin
                    freq_d     = freq_i;
                    half_cnt_d = 8'd0;
                    dur_cnt_d  = '0;
                    tone_d     = 1'b0;
                end else if (tick) begin
                    if (half_cnt_q == freq_q - 8'd1) begin
                        half_cnt_d = 8'd0;
                        tone_d     = ~tone_q;
                    end else begin
                        half_cnt_d = half_cnt_q + 8'd1;
                    end
                    if (dur_cnt_q == DurLast) begin
                        state_d = StIdle;
                        tone_d  = 1'b0;
                    end else begin
                        dur_cnt_d = dur_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            prev_q     <= 8'd0;
            freq_q     <= 8'd0;
            half_cnt_q <= 8'd0;
            dur_cnt_q  <= '0;
            tone_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= freq_i;
            freq_q     <= freq_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_q     <= tone_d;
        end
    end

    assign busy_o   = playing;
    assign square_o = tone_q & ~mute_i & playing;

endmodule

// File: tb/tb_t09_sound_generator.sv
// Directed bench for t09_sound_generator with PRESCALE=4, DUR_TICKS=20.
// Table vectors: drive inputs, wait N edges, sample 1 ns after the edge.
`timescale 1ns/1ps
module tb_t09_sound_generator;

    logic       clk;
    logic       nrst;
    logic [7:0] freq_i;
    logic       mute_i;
    logic       square_o;
    logic       busy_o;

    int n_vec;
    int n_bad;

    typedef struct {
        string       name;
        int unsigned wait_cyc;
        logic [7:0]  freq;
        logic        mute;
        logic        exp_sq;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    t09_sound_generator #(
        .PRESCALE  (4),
        .DUR_TICKS (20)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .freq_i   (freq_i),
        .mute_i   (mute_i),
        .square_o (square_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input int unsigned w, input logic [7:0] f,
                       input logic m, input logic sq, input logic bz);
        vec_t v;
        v.name = name; v.wait_cyc = w; v.freq = f; v.mute = m;
        v.exp_sq = sq; v.exp_busy = bz;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        nrst   = 1'b0;
        freq_i = 8'd89;
        mute_i = 1'b0;

        // k = edges since load; square high for k in [12,24),[36,48),[60,72) at freq 3
        add("t2_load",     1, 8'd3, 1'b0, 1'b0, 1'b1);
        add("t2_k11",     11, 8'd0, 1'b0, 1'b0, 1'b1);
        add("t2_k12",      1, 8'd0, 1'b0, 1'b1, 1'b1);
        add("t2_k23",     11, 8'd0, 1'b0, 1'b1, 1'b1);
        add("t2_k24",      1, 8'd0, 1'b0, 1'b0, 1'b1);
        add("t2_k36",     12, 8'd0, 1'b0, 1'b1, 1'b1);
        add("t2_k72",     36, 8'd0, 1'b0, 1'b0, 1'b1);
        add("t2_k79",      7, 8'd0, 1'b0, 1'b0, 1'b1);
        add("t2_k80",      1, 8'd0, 1'b0, 1'b0, 1'b0);
        add("t3_load",     1, 8'd3, 1'b0, 1'b0, 1'b1);
        add("t3_k79",     79, 8'd3, 1'b0, 1'b0, 1'b1);
        add("t3_k80",      1, 8'd3, 1'b0, 1'b0, 1'b0);
        add("t3_k199",   119, 8'd3, 1'b0, 1'b0, 1'b0);
        add("t3_drop",     2, 8'd0, 1'b0, 1'b0, 1'b0);
        add("t5_load",     1, 8'd3, 1'b0, 1'b0, 1'b1);
        add("t5_k12mute", 12, 8'd0, 1'b1, 1'b0, 1'b1);
        add("t5_k13open",  1, 8'd0, 1'b0, 1'b1, 1'b1);
        add("t5_k79mute", 66, 8'd0, 1'b1, 1'b0, 1'b1);
        add("t5_k80",      1, 8'd0, 1'b1, 1'b0, 1'b0);
        add("t5_unmute",   2, 8'd0, 1'b0, 1'b0, 1'b0);
        // Retrigger lands on the expiry edge: tone must restart
        add("tx_load",     1, 8'd3, 1'b0, 1'b0, 1'b1);
        add("tx_k79",     79, 8'd0, 1'b0, 1'b0, 1'b1);
        add("tx_k80trig",  1, 8'd5, 1'b0, 1'b0, 1'b1);
        add("tx_r19",     19, 8'd0, 1'b0, 1'b0, 1'b1);
        add("tx_r20",      1, 8'd0, 1'b0, 1'b1, 1'b1);
        add("tx_r79",     59, 8'd0, 1'b0, 1'b1, 1'b1);
        add("tx_r80",      1, 8'd0, 1'b0, 1'b0, 1'b0);

        // Test 1: reset with a code held, then a single trigger on release
        step(3);
        check("t1_rst_sq", square_o, 1'b0);
        check("t1_rst_busy", busy_o, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        step(1);
        check("t1_release_busy", busy_o, 1'b1);
        step(79);
        check("t1_k79_busy", busy_o, 1'b1);
        check("t1_k79_sq", square_o, 1'b0);
        step(1);
        check("t1_k80_busy", busy_o, 1'b0);
        step(20);
        check("t1_no_retrig", busy_o, 1'b0);
        freq_i = 8'd0;
        step(2);

        foreach (vecs[i]) begin
            freq_i = vecs[i].freq;
            mute_i = vecs[i].mute;
            step(int'(vecs[i].wait_cyc));
            check({vecs[i].name, "_sq"}, square_o, vecs[i].exp_sq);
            check({vecs[i].name, "_busy"}, busy_o, vecs[i].exp_busy);
        end

        // Test 4: code change mid-tone restarts at cycle 31
        freq_i = 8'd3;
        step(1);
        check("t4_load_busy", busy_o, 1'b1);
        step(30);
        check("t4_k30_sq", square_o, 1'b0);
        freq_i = 8'd5;
        step(1);
        check("t4_restart_busy", busy_o, 1'b1);
        step(5);
        check("t4_r5_sq", square_o, 1'b0);
        step(14);
        check("t4_r19_sq", square_o, 1'b0);
        step(1);
        check("t4_r20_sq", square_o, 1'b1);
        step(59);
        check("t4_r79_busy", busy_o, 1'b1);
        step(1);
        check("t4_r80_busy", busy_o, 1'b0);
        freq_i = 8'd0;
        step(2);

        // Test 6: asynchronous reset mid-tone
        freq_i = 8'd3;
        step(1);
        freq_i = 8'd0;
        step(40);
        check("t6_k40_sq", square_o, 1'b1);
        check("t6_k40_busy", busy_o, 1'b1);
        #3 nrst = 1'b0;
        #1;
        check("t6_async_sq", square_o, 1'b0);
        check("t6_async_busy", busy_o, 1'b0);
        step(2);
        @(negedge clk);
        nrst = 1'b1;
        step(5);
        check("t6_idle_busy", busy_o, 1'b0);
        check("t6_idle_sq", square_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
